// File: rtl/jtsbaskt_dwnld_fmt_pkg.sv
// Shared types and constants for the Super Basketball download formatter.
package jtsbaskt_pkg;

  // Byte classification by download address
  typedef enum logic [1:0] {
    REG_SDRAM = 2'd0,
    REG_GFX   = 2'd1,
    REG_PROM  = 2'd2
  } region_t;

  // SDRAM write sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fsm_state_t;

  // Active-low byte-lane masks: a 0 bit enables that lane
  localparam logic [1:0] MASK_UPPER = 2'b01;
  localparam logic [1:0] MASK_LOWER = 2'b10;

  // FIFO entry: {word address[21:0], byte[7:0], lane}
  localparam int FIFO_W = 31;

  // Graphics ROMs are stored with their nibbles exchanged
  function automatic logic [7:0] nib_swap(input logic [7:0] d);
    return {d[3:0], d[7:4]};
  endfunction

endpackage

// File: rtl/jtsbaskt_dwnld_fmt_fifo.sv
// Two-entry FIFO holding SDRAM writes until they are acknowledged.
module jtsbaskt_dwnld_fifo
  import jtsbaskt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [FIFO_W-1:0] i_din,
  input  logic              i_pop,
  output logic [FIFO_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty
);

  logic [FIFO_W-1:0] r_mem [0:1];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rptr];

  // Entry storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/jtsbaskt_dwnld_fmt.sv
// Download formatter: classifies ioctl bytes, swaps graphics nibbles, queues
// SDRAM word writes and strobes PROM bytes directly.
// Optional feature: define JTSBASKT_DWNLD_CHKSUM_EN for the running checksum.
module jtsbaskt_dwnld_fmt
  import jtsbaskt_pkg::*;
#(
  parameter logic [21:0] SCR_START  = 22'h0,
  parameter logic [21:0] PCM_START  = 22'h0,
  parameter logic [24:0] PROM_START = 25'h0,
  parameter logic        SWAB       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  input  logic        sdram_ack,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        prom_we,
  output logic [10:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic        dwnld_busy,
  output logic        ovf,
  output logic [7:0]  chksum
);

  region_t           w_region;
  logic [7:0]        w_byte;
  logic              w_wr;
  logic              w_prom_wr;
  logic              w_sd_wr;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_W-1:0] w_head;
  logic [10:0]       w_prom_off;
  fsm_state_t        r_state;
  fsm_state_t        w_state_nxt;
  logic              w_load;
  logic              w_pop;
  logic [21:0]       r_prog_addr;
  logic [15:0]       r_prog_data;
  logic [1:0]        r_prog_mask;
  logic              r_prog_we;
  logic              r_prom_we;
  logic [10:0]       r_prom_addr;
  logic [7:0]        r_prom_data;
  logic              r_ovf;

  // Region decode: PROM wins over the graphics window
  always_comb begin
    w_region = REG_SDRAM;
    if (ioctl_addr >= PROM_START) begin
      w_region = REG_PROM;
    end else if ((ioctl_addr[21:0] >= SCR_START) && (ioctl_addr[21:0] < PCM_START)) begin
      w_region = REG_GFX;
    end else begin
      w_region = REG_SDRAM;
    end
  end

  // Byte transform by region
  always_comb begin
    w_byte = ioctl_dout;
    case (w_region)
      REG_GFX: w_byte = nib_swap(ioctl_dout);
      default: w_byte = ioctl_dout;
    endcase
  end

  assign w_wr       = ioctl_wr & downloading;
  assign w_prom_wr  = w_wr & (w_region == REG_PROM);
  assign w_sd_wr    = w_wr & (w_region != REG_PROM);
  assign w_push     = w_sd_wr & ~w_full;
  // Only the low 11 bits of the PROM offset are needed, so subtract narrow
  assign w_prom_off = ioctl_addr[10:0] - PROM_START[10:0];

  // The head entry stays queued until acknowledged, so the in-flight write
  // occupies one of the two slots.
  jtsbaskt_dwnld_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({ioctl_addr[22:1], w_byte, ioctl_addr[0] ^ SWAB}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sequencer next state: load head from IDLE, release it on acknowledge
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_WAIT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (sdram_ack) begin
          w_state_nxt = ST_IDLE;
          w_pop       = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state and SDRAM request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prog_we   <= 1'b0;
      r_prog_addr <= 22'h0;
      r_prog_data <= 16'h0;
      r_prog_mask <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_prog_we <= (w_state_nxt == ST_WAIT);
      if (w_load) begin
        r_prog_addr <= w_head[30:9];
        r_prog_data <= {w_head[8:1], w_head[8:1]};
        r_prog_mask <= w_head[0] ? MASK_UPPER : MASK_LOWER;
      end
    end
  end

  // PROM strobe path and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prom_we   <= 1'b0;
      r_prom_addr <= 11'h0;
      r_prom_data <= 8'h0;
      r_ovf       <= 1'b0;
    end else begin
      r_prom_we <= w_prom_wr;
      if (w_prom_wr) begin
        r_prom_addr <= w_prom_off;
        r_prom_data <= ioctl_dout;
      end
      if (w_sd_wr && w_full) r_ovf <= 1'b1;
    end
  end

`ifdef JTSBASKT_DWNLD_CHKSUM_EN
  logic       r_dl_q;
  logic [7:0] r_chksum;
  logic [7:0] w_ck_base;
  logic [7:0] w_ck_add;

  // Restart on a new download; sum raw bytes that were actually accepted
  always_comb begin
    w_ck_base = r_chksum;
    w_ck_add  = 8'h00;
    if (downloading && !r_dl_q) begin
      w_ck_base = 8'h00;
    end else begin
      w_ck_base = r_chksum;
    end
    if (w_prom_wr || w_push) begin
      w_ck_add = ioctl_dout;
    end else begin
      w_ck_add = 8'h00;
    end
  end

  // Checksum accumulator and downloading edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_q   <= 1'b0;
      r_chksum <= 8'h00;
    end else begin
      r_dl_q   <= downloading;
      r_chksum <= w_ck_base + w_ck_add;
    end
  end

  assign chksum = r_chksum;
`else
  assign chksum = 8'h00;
`endif

  assign prog_addr  = r_prog_addr;
  assign prog_data  = r_prog_data;
  assign prog_mask  = r_prog_mask;
  assign prog_we    = r_prog_we;
  assign prom_we    = r_prom_we;
  assign prom_addr  = r_prom_addr;
  assign prom_data  = r_prom_data;
  assign ovf        = r_ovf;
  assign dwnld_busy = downloading | (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_jtsbaskt_dwnld_fmt.sv
// Directed self-checking bench for jtsbaskt_dwnld_fmt.
module tb_jtsbaskt_dwnld_fmt;

  logic        clk;
  logic        rst;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        sdram_ack;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prom_we;
  logic [10:0] prom_addr;
  logic [7:0]  prom_data;
  logic        dwnld_busy;
  logic        ovf;
  logic [7:0]  chksum;

  int n_pass  = 0;
  int n_total = 0;

  jtsbaskt_dwnld_fmt #(
    .SCR_START  (22'h8000),
    .PCM_START  (22'h10000),
    .PROM_START (25'h1_C000),
    .SWAB       (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .sdram_ack   (sdram_ack),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .dwnld_busy  (dwnld_busy),
    .ovf         (ovf),
    .chksum      (chksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle ioctl write
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack_once;
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; downloading = 1'b0; ioctl_addr = 25'h0; ioctl_dout = 8'h0;
    ioctl_wr = 1'b0; sdram_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_total++; if (prog_we !== 1'b0) $display("FAIL rst_prog_we act=%0b exp=0", prog_we); else n_pass++;
    n_total++; if (prom_we !== 1'b0) $display("FAIL rst_prom_we act=%0b exp=0", prom_we); else n_pass++;
    n_total++; if ({prog_addr, prog_data, prog_mask} !== 40'h0) $display("FAIL rst_prog_bus act=%h/%h/%b exp=0", prog_addr, prog_data, prog_mask); else n_pass++;
    n_total++; if ({ovf, dwnld_busy, chksum} !== 10'h0) $display("FAIL rst_flags act=ovf%0b busy%0b ck%h exp=0", ovf, dwnld_busy, chksum); else n_pass++;
  endtask

  task automatic test_sdram_gfx;
    downloading = 1'b1;
    tick();
    wr_byte(25'h8001, 8'hA5);
    n_total++; if (prog_we !== 1'b0) $display("FAIL gfx_we_lat1 act=%0b exp=0", prog_we); else n_pass++;
    tick();
    n_total++; if (prog_we !== 1'b1) $display("FAIL gfx_we_lat2 act=%0b exp=1", prog_we); else n_pass++;
    n_total++; if (prog_data !== 16'h5A5A) $display("FAIL gfx_data act=%h exp=5a5a", prog_data); else n_pass++;
    n_total++; if (prog_addr !== 22'h4000) $display("FAIL gfx_addr act=%h exp=4000", prog_addr); else n_pass++;
    n_total++; if (prog_mask !== 2'b10) $display("FAIL gfx_mask act=%b exp=10", prog_mask); else n_pass++;
    tick(); tick(); tick();
    n_total++; if ({prog_we, prog_data, prog_mask} !== {1'b1, 16'h5A5A, 2'b10}) $display("FAIL gfx_hold act=%0b/%h/%b exp=1/5a5a/10", prog_we, prog_data, prog_mask); else n_pass++;
    ack_once();
    n_total++; if (prog_we !== 1'b0) $display("FAIL gfx_drop act=%0b exp=0", prog_we); else n_pass++;
    // plain SDRAM byte, even address -> upper lane, no swap
    wr_byte(25'h0_0010, 8'hA5);
    tick();
    n_total++; if ({prog_we, prog_addr, prog_data, prog_mask} !== {1'b1, 22'h8, 16'hA5A5, 2'b01}) $display("FAIL plain_wr act=%0b/%h/%h/%b exp=1/8/a5a5/01", prog_we, prog_addr, prog_data, prog_mask); else n_pass++;
    ack_once();
    // above the graphics window: passes through unchanged
    wr_byte(25'h1_0003, 8'hC3);
    tick();
    n_total++; if ({prog_addr, prog_data, prog_mask} !== {22'h8001, 16'hC3C3, 2'b10}) $display("FAIL pcm_wr act=%h/%h/%b exp=8001/c3c3/10", prog_addr, prog_data, prog_mask); else n_pass++;
    ack_once();
  endtask

  task automatic test_prom;
    wr_byte(25'h1_C123, 8'h3C);
    n_total++; if ({prom_we, prom_addr, prom_data} !== {1'b1, 11'h123, 8'h3C}) $display("FAIL prom_strobe act=%0b/%h/%h exp=1/123/3c", prom_we, prom_addr, prom_data); else n_pass++;
    n_total++; if (prog_we !== 1'b0) $display("FAIL prom_prog_we act=%0b exp=0", prog_we); else n_pass++;
    tick();
    n_total++; if ({prom_we, prog_we} !== 2'b00) $display("FAIL prom_one_cycle act=%b exp=00", {prom_we, prog_we}); else n_pass++;
  endtask

  task automatic test_overflow;
    wr_byte(25'h0_0020, 8'h11);
    wr_byte(25'h0_0022, 8'h22);
    wr_byte(25'h0_0024, 8'h33);
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_set act=%0b exp=1", ovf); else n_pass++;
    n_total++; if ({prog_we, prog_addr, prog_data} !== {1'b1, 22'h10, 16'h1111}) $display("FAIL ovf_first act=%0b/%h/%h exp=1/10/1111", prog_we, prog_addr, prog_data); else n_pass++;
    ack_once();
    n_total++; if (prog_we !== 1'b0) $display("FAIL ovf_dead act=%0b exp=0", prog_we); else n_pass++;
    tick();
    n_total++; if ({prog_we, prog_addr, prog_data} !== {1'b1, 22'h11, 16'h2222}) $display("FAIL ovf_second act=%0b/%h/%h exp=1/11/2222", prog_we, prog_addr, prog_data); else n_pass++;
    ack_once();
    tick(); tick();
    n_total++; if (prog_we !== 1'b0) $display("FAIL ovf_no_third act=%0b exp=0", prog_we); else n_pass++;
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky act=%0b exp=1", ovf); else n_pass++;
  endtask

  task automatic test_busy_drain;
    wr_byte(25'h0_0030, 8'h44);
    downloading = 1'b0;
    tick();
    n_total++; if ({prog_we, dwnld_busy} !== 2'b11) $display("FAIL drain_pending act=%b exp=11", {prog_we, dwnld_busy}); else n_pass++;
    tick(); tick();
    n_total++; if (dwnld_busy !== 1'b1) $display("FAIL drain_hold act=%0b exp=1", dwnld_busy); else n_pass++;
    ack_once();
    n_total++; if ({prog_we, dwnld_busy} !== 2'b00) $display("FAIL drain_done act=%b exp=00", {prog_we, dwnld_busy}); else n_pass++;
  endtask

  task automatic test_reset_mid_write;
    downloading = 1'b1;
    tick();
    wr_byte(25'h0_0040, 8'h55);
    tick();
    n_total++; if (prog_we !== 1'b1) $display("FAIL midrst_pre act=%0b exp=1", prog_we); else n_pass++;
    rst = 1'b1;
    downloading = 1'b0;
    tick();
    n_total++; if ({prog_we, ovf, dwnld_busy} !== 3'b000) $display("FAIL midrst_clear act=we%0b ovf%0b busy%0b exp=000", prog_we, ovf, dwnld_busy); else n_pass++;
    rst = 1'b0;
    ack_once();
    tick();
    n_total++; if ({prog_we, dwnld_busy} !== 2'b00) $display("FAIL midrst_ack_ignored act=%b exp=00", {prog_we, dwnld_busy}); else n_pass++;
  endtask

  task automatic test_ignored_wr;
    downloading = 1'b0;
    wr_byte(25'h0_0050, 8'h66);
    n_total++; if (prom_we !== 1'b0) $display("FAIL ign_prom act=%0b exp=0", prom_we); else n_pass++;
    wr_byte(25'h1_C001, 8'h77);
    tick();
    n_total++; if ({prog_we, prom_we, dwnld_busy} !== 3'b000) $display("FAIL ign_wr act=%b exp=000", {prog_we, prom_we, dwnld_busy}); else n_pass++;
  endtask

  task automatic test_chksum;
    downloading = 1'b1;
    tick();
    wr_byte(25'h0_0060, 8'hF0);
    wr_byte(25'h1_C000, 8'h20);
    wr_byte(25'h0_0062, 8'h05);
`ifdef JTSBASKT_DWNLD_CHKSUM_EN
    n_total++; if (chksum !== 8'h15) $display("FAIL chksum_sum act=%h exp=15", chksum); else n_pass++;
`else
    n_total++; if (chksum !== 8'h00) $display("FAIL chksum_tied act=%h exp=00", chksum); else n_pass++;
`endif
    ack_once();
    tick();
    ack_once();
    downloading = 1'b0;
    tick();
    downloading = 1'b1;
    tick();
    n_total++; if (chksum !== 8'h00) $display("FAIL chksum_restart act=%h exp=00", chksum); else n_pass++;
    n_total++; if (prog_we !== 1'b0) $display("FAIL chksum_drained act=%0b exp=0", prog_we); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sdram_gfx();
    test_prom();
    test_overflow();
    test_busy_drain();
    test_reset_mid_write();
    test_ignored_wr();
    test_chksum();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
